// File: rtl/rf_bridge_pkg.sv
// Shared types for the APB-to-register-file bridge: FSM states, word
// select encodings and the address decode result.
package rf_bridge_pkg;

  // Register index width carried in the decode result; the bridge's NADDR
  // parameter must match it.
  localparam int IDX_W = 4;

  localparam logic WSEL_LO = 1'b0;
  localparam logic WSEL_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACC_FAST,
    RD_ISSUE,
    RD_DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             wsel;
    logic             err;
  } dec_t;

endpackage

// File: rtl/rf_addr_decode.sv
// Combinational APB byte-address decode: register index, word select and
// decode error (misaligned, stray upper bits, or index beyond NREG).
module rf_addr_decode
  import rf_bridge_pkg::*;
#(
  parameter int NADDR  = 4,
  parameter int NREG   = 16,
  parameter int APB_AW = 8
) (
  input  logic [APB_AW-1:0] i_paddr,
  output dec_t              o_dec
);

  logic             w_hi_nz;
  logic [NADDR-1:0] w_idx;

  generate
    if (APB_AW > NADDR + 3) begin : g_hi
      assign w_hi_nz = |i_paddr[APB_AW-1:NADDR+3];
    end else begin : g_nohi
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  assign w_idx = i_paddr[NADDR+2:3];

  // Assemble the decode result from the address fields.
  always_comb begin
    o_dec      = '0;
    o_dec.idx  = IDX_W'(w_idx);
    o_dec.wsel = i_paddr[2];
    o_dec.err  = (i_paddr[1:0] != 2'b00) | w_hi_nz |
                 ({1'b0, w_idx} >= (NADDR+1)'(NREG));
  end

endmodule

// File: rtl/rf_apb_bridge.sv
// APB slave exposing each 64-bit register as two 32-bit words. Low writes
// stage in a shadow, high writes commit all 64 bits; low reads fetch the
// whole register and park the upper half for the following high read.
module rf_apb_bridge
  import rf_bridge_pkg::*;
#(
  parameter int NBIT   = 64,
  parameter int NREG   = 16,
  parameter int NADDR  = 4,
  parameter int APB_AW = 8,
  parameter int APB_DW = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              RF_ENABLE,
  output logic              RF_WR,
  output logic [NADDR-1:0]  RF_ADD,
  output logic [NBIT-1:0]   RF_DATAIN,
  input  logic [NBIT-1:0]   RF_OUT1
);

  dec_t             w_dec;
  logic [NADDR-1:0] w_idx;
  logic             w_setup;
  logic             w_wsh_hit;
  logic             w_rb_hit;

  state_t            r_state;
  logic              r_pready;
  logic              r_pslverr;
  logic [APB_DW-1:0] r_prdata;
  logic              r_rf_en;
  logic              r_rf_wr;
  logic [NADDR-1:0]  r_rf_add;
  logic [NBIT-1:0]   r_rf_din;
  logic [APB_DW-1:0] r_wshadow;
  logic [NADDR-1:0]  r_wsh_idx;
  logic              r_wsh_vld;
  logic [APB_DW-1:0] r_rbuf;
  logic [NADDR-1:0]  r_rb_idx;
  logic              r_rb_vld;
  // Transfer in flight; its side effects are applied only on completion so
  // an aborted transfer leaves shadow and buffer untouched.
  logic [NADDR-1:0]  r_cur_idx;
  logic [APB_DW-1:0] r_cur_wdata;
  logic              r_upd_wlo;
  logic              r_upd_whi;
  logic              r_upd_rhi;

  rf_addr_decode #(
    .NADDR (NADDR),
    .NREG  (NREG),
    .APB_AW(APB_AW)
  ) u_dec (
    .i_paddr(PADDR),
    .o_dec  (w_dec)
  );

  assign w_idx     = w_dec.idx[NADDR-1:0];
  assign w_setup   = PSEL & ~PENABLE;
  assign w_wsh_hit = r_wsh_vld & (r_wsh_idx == w_idx);
  assign w_rb_hit  = r_rb_vld & (r_rb_idx == w_idx);

  // Transfer FSM: decode at setup, register responses and RF strobes for
  // the first access cycle, commit shadow/buffer updates at completion.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_prdata    <= '0;
      r_rf_en     <= 1'b0;
      r_rf_wr     <= 1'b0;
      r_rf_add    <= '0;
      r_rf_din    <= '0;
      r_wshadow   <= '0;
      r_wsh_idx   <= '0;
      r_wsh_vld   <= 1'b0;
      r_rbuf      <= '0;
      r_rb_idx    <= '0;
      r_rb_vld    <= 1'b0;
      r_cur_idx   <= '0;
      r_cur_wdata <= '0;
      r_upd_wlo   <= 1'b0;
      r_upd_whi   <= 1'b0;
      r_upd_rhi   <= 1'b0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_rf_en   <= 1'b0;
      r_rf_wr   <= 1'b0;
      r_upd_wlo <= 1'b0;
      r_upd_whi <= 1'b0;
      r_upd_rhi <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_cur_idx   <= w_idx;
            r_cur_wdata <= PWDATA;
            if (w_dec.err) begin
              r_state   <= ACC_FAST;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end else if (PWRITE && w_dec.wsel == WSEL_LO) begin
              r_state   <= ACC_FAST;
              r_pready  <= 1'b1;
              r_upd_wlo <= 1'b1;
            end else if (PWRITE) begin
              r_state  <= ACC_FAST;
              r_pready <= 1'b1;
              if (w_wsh_hit) begin
                r_rf_wr   <= 1'b1;
                r_rf_en   <= 1'b1;
                r_rf_add  <= w_idx;
                r_rf_din  <= {PWDATA, r_wshadow};
                r_upd_whi <= 1'b1;
              end else begin
                r_pslverr <= 1'b1;
              end
            end else if (w_dec.wsel == WSEL_LO) begin
              r_state  <= RD_ISSUE;
              r_rf_en  <= 1'b1;
              r_rf_add <= w_idx;
            end else begin
              r_state  <= ACC_FAST;
              r_pready <= 1'b1;
              if (w_rb_hit) begin
                r_prdata  <= r_rbuf;
                r_upd_rhi <= 1'b1;
              end else begin
                r_pslverr <= 1'b1;
              end
            end
          end
        end
        ACC_FAST: begin
          r_state <= IDLE;
          if (PSEL) begin
            if (r_upd_wlo) begin
              r_wshadow <= r_cur_wdata;
              r_wsh_idx <= r_cur_idx;
              r_wsh_vld <= 1'b1;
            end
            if (r_upd_whi) begin
              r_wsh_vld <= 1'b0;
              if (r_rb_idx == r_cur_idx) r_rb_vld <= 1'b0;
            end
            if (r_upd_rhi) r_rb_vld <= 1'b0;
          end
        end
        RD_ISSUE: begin
          if (PSEL) begin
            r_state  <= RD_DONE;
            r_pready <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_DONE: begin
          r_state <= IDLE;
          if (PSEL) begin
            r_rbuf   <= RF_OUT1[NBIT-1:APB_DW];
            r_rb_idx <= r_cur_idx;
            r_rb_vld <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The low read word comes straight from the RF output in its valid cycle;
  // strobes are masked by PSEL so an abandoned transfer touches nothing.
  assign PRDATA    = (r_state == RD_DONE) ? RF_OUT1[APB_DW-1:0] : r_prdata;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pslverr;
  assign RF_ENABLE = r_rf_en & PSEL;
  assign RF_WR     = r_rf_wr & PSEL;
  assign RF_ADD    = r_rf_add;
  assign RF_DATAIN = r_rf_din;

endmodule

// File: tb/tb_rf_apb_bridge.sv
// Bench for rf_apb_bridge: transaction-level model of the word/shadow/buffer
// rules, a register-file responder, and a per-cycle compare process.
module tb_rf_apb_bridge;
  localparam int NBIT = 64, NREG = 16, NADDR = 4, APB_AW = 8, APB_DW = 32;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, RF_ENABLE, RF_WR;
  logic [3:0]  RF_ADD;
  logic [63:0] RF_DATAIN;
  logic [63:0] RF_OUT1;

  always #5 CLK = ~CLK;

  rf_apb_bridge #(
    .NBIT(NBIT), .NREG(NREG), .NADDR(NADDR), .APB_AW(APB_AW), .APB_DW(APB_DW)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .RF_ENABLE(RF_ENABLE), .RF_WR(RF_WR),
    .RF_ADD(RF_ADD), .RF_DATAIN(RF_DATAIN), .RF_OUT1(RF_OUT1)
  );

  function automatic logic [63:0] seedval(int i);
    return {32'hC0DE0000 + 32'(i), 32'h0BAD0000 + 32'(i * 7)};
  endfunction

  // Register file responder: writes on WR, registered read on ENABLE.
  logic [63:0] rfm [NREG];
  logic        init_rf = 1'b1;
  always @(posedge CLK) begin
    if (init_rf) begin
      for (int i = 0; i < NREG; i++) rfm[4'(i)] <= seedval(i);
      RF_OUT1 <= '0;
    end else begin
      if (RF_WR) rfm[RF_ADD] <= RF_DATAIN;
      if (RF_ENABLE && !RF_WR) RF_OUT1 <= rfm[RF_ADD];
    end
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, set by the driver.
  bit          chk_on = 1'b0;
  logic        e_pready, e_slverr, e_chkrd, e_rfwr, e_rfen;
  logic [31:0] e_prdata;
  logic [3:0]  e_add;
  logic [63:0] e_din;
  int          n_rfwr = 0;
  logic [3:0]  seen_wadd;
  logic [63:0] seen_wdin;
  logic [31:0] seen_prdata;
  logic        seen_slverr;

  // Per-cycle compare against the model's expectations.
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("pready", 64'(PREADY), 64'(e_pready));
      chk("rf_wr", 64'(RF_WR), 64'(e_rfwr));
      chk("rf_en", 64'(RF_ENABLE), 64'(e_rfen));
      if (e_pready) chk("pslverr", 64'(PSLVERR), 64'(e_slverr));
      if (e_chkrd) chk("prdata", 64'(PRDATA), 64'(e_prdata));
      if (e_rfen || e_rfwr) chk("rf_add", 64'(RF_ADD), 64'(e_add));
      if (e_rfwr) chk("rf_din", RF_DATAIN, e_din);
      if (RF_WR) begin n_rfwr++; seen_wadd = RF_ADD; seen_wdin = RF_DATAIN; end
      if (PREADY) begin seen_prdata = PRDATA; seen_slverr = PSLVERR; end
    end
  end

  // Behavioural model state.
  logic [63:0] mm [NREG];
  logic [31:0] sh_val, rb_val;
  logic [3:0]  sh_idx, rb_idx;
  bit          sh_vld, rb_vld;

  task automatic set_exp(input bit rdy, input bit se, input bit crd, input logic [31:0] rd,
                         input bit wr, input bit en, input logic [3:0] add, input logic [63:0] din);
    e_pready = rdy; e_slverr = se; e_chkrd = crd; e_prdata = rd;
    e_rfwr = wr; e_rfen = en; e_add = add; e_din = din;
  endtask

  task automatic quiet();
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 64'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1; PSEL = 1'b0; PENABLE = 1'b0; quiet();
      @(negedge CLK); #1;
    end
  endtask

  task automatic setup(input bit wr, input logic [7:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d; quiet();
    @(negedge CLK); #1;
  endtask

  task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] d);
    bit [31:0]  au;
    bit         err, hi;
    logic [3:0] i4;
    au  = 32'(a);
    err = (au % 4 != 0) || (au / 8 >= NREG);
    hi  = ((au / 4) % 2) == 1;
    i4  = a[6:3];
    setup(wr, a, d);
    @(posedge CLK); #1; PENABLE = 1'b1;
    if (err) begin
      set_exp(1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 4'd0, 64'd0);
    end else if (wr && !hi) begin
      set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 64'd0);
      sh_val = d; sh_idx = i4; sh_vld = 1'b1;
    end else if (wr) begin
      if (sh_vld && sh_idx == i4) begin
        set_exp(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, i4, {d, sh_val});
        mm[i4] = {d, sh_val};
        sh_vld = 1'b0;
        if (rb_vld && rb_idx == i4) rb_vld = 1'b0;
      end else begin
        set_exp(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 64'd0);
      end
    end else if (hi) begin
      if (rb_vld && rb_idx == i4) begin
        set_exp(1'b1, 1'b0, 1'b1, rb_val, 1'b0, 1'b0, 4'd0, 64'd0);
        rb_vld = 1'b0;
      end else begin
        set_exp(1'b1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 4'd0, 64'd0);
      end
    end else begin
      set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, i4, 64'd0);
      @(negedge CLK); #1;
      @(posedge CLK); #1;
      set_exp(1'b1, 1'b0, 1'b1, mm[i4][31:0], 1'b0, 1'b0, 4'd0, 64'd0);
      rb_val = mm[i4][63:32]; rb_idx = i4; rb_vld = 1'b1;
    end
    @(negedge CLK); #1;
  endtask

  // Low read abandoned in its wait state: nothing must happen.
  task automatic apb_abort_rdlo(input logic [7:0] a);
    setup(1'b0, a, 32'd0);
    @(posedge CLK); #1; PSEL = 1'b0; PENABLE = 1'b0; quiet();
    @(negedge CLK); #1;
  endtask

  // Low read hit by reset during its wait state.
  task automatic apb_rst_rdlo(input logic [7:0] a);
    setup(1'b0, a, 32'd0);
    @(posedge CLK); #1; PENABLE = 1'b1; RESET_N = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, a[6:3], 64'd0);
    @(negedge CLK); #1;
    @(posedge CLK); #1; RESET_N = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; quiet();
    sh_val = '0; sh_vld = 1'b0; rb_val = '0; rb_vld = 1'b0;
    @(negedge CLK); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  int          n0, sel, ix;
  logic [31:0] dd;
  initial begin
    for (int i = 0; i < NREG; i++) mm[4'(i)] = seedval(i);
    sh_val = '0; sh_idx = '0; sh_vld = 1'b0;
    rb_val = '0; rb_idx = '0; rb_vld = 1'b0;
    quiet();
    repeat (3) @(posedge CLK);
    #1; chk_on = 1'b1;
    @(negedge CLK); #1;
    chk("rst_prdata", 64'(PRDATA), 64'd0);
    chk("rst_pready", 64'(PREADY), 64'd0);
    chk("rst_pslverr", 64'(PSLVERR), 64'd0);
    chk("rst_rf_add", 64'(RF_ADD), 64'd0);
    chk("rst_rf_din", RF_DATAIN, 64'd0);
    @(posedge CLK); #1; init_rf = 1'b0; RESET_N = 1'b1;
    @(negedge CLK); #1;

    n0 = n_rfwr;
    apb(1'b1, 8'h18, 32'h11112222); chk("wlo_slverr", 64'(seen_slverr), 64'd0);
    apb(1'b1, 8'h1C, 32'hAAAABBBB); chk("whi_slverr", 64'(seen_slverr), 64'd0);
    chk("wr_pulses", 64'(n_rfwr - n0), 64'd1);
    chk("wr_add", 64'(seen_wadd), 64'd3);
    chk("wr_din", seen_wdin, 64'hAAAABBBB11112222);
    apb(1'b0, 8'h18, 32'd0); chk("rlo_data", 64'(seen_prdata), 64'h11112222);
    apb(1'b0, 8'h1C, 32'd0); chk("rhi_data", 64'(seen_prdata), 64'hAAAABBBB);
    apb(1'b0, 8'h1C, 32'd0); chk("rhi2_slverr", 64'(seen_slverr), 64'd1);

    n0 = n_rfwr;
    apb(1'b1, 8'h2C, 32'h1); chk("whi_nolo", 64'(seen_slverr), 64'd1);
    apb(1'b1, 8'h20, 32'h2);
    apb(1'b1, 8'h2C, 32'h3); chk("whi_mismatch", 64'(seen_slverr), 64'd1);
    chk("no_rf_wr", 64'(n_rfwr - n0), 64'd0);

    apb(1'b0, 8'h81, 32'd0); chk("misalign_err", 64'(seen_slverr), 64'd1);
    apb(1'b0, 8'h80, 32'd0); chk("oob_err", 64'(seen_slverr), 64'd1);
    chk("oob_prdata", 64'(seen_prdata), 64'd0);
    idle(1);

    apb_rst_rdlo(8'h00);
    chk("rst_mid_pready", 64'(PREADY), 64'd0);
    apb(1'b1, 8'h04, 32'h5); chk("rst_whi", 64'(seen_slverr), 64'd1);
    apb(1'b0, 8'h04, 32'd0); chk("rst_rhi", 64'(seen_slverr), 64'd1);
    idle(2);

    apb(1'b0, 8'h00, 32'd0); chk("b2b_rd", 64'(seen_prdata), 64'(seedval(0) & 64'hFFFFFFFF));
    apb(1'b1, 8'h08, 32'h77); chk("b2b_wr", 64'(seen_slverr), 64'd0);

    apb(1'b0, 8'h18, 32'd0);
    apb_abort_rdlo(8'h10);
    apb(1'b0, 8'h1C, 32'd0); chk("abort_rb", 64'(seen_prdata), 64'hAAAABBBB);

    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 9);
      ix  = $urandom_range(0, 3);
      dd  = $urandom;
      case (sel)
        0, 1, 2: begin
          apb(1'b1, 8'(ix * 8), dd);
          apb(1'b1, 8'(ix * 8 + 4), $urandom);
        end
        3, 4: begin
          apb(1'b0, 8'(ix * 8), 32'd0);
          apb(1'b0, 8'(ix * 8 + 4), 32'd0);
        end
        5: apb(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), dd);
        6: apb(1'($urandom_range(0, 1)), 8'(ix * 8 + 4 * $urandom_range(0, 1)), dd);
        7: idle($urandom_range(1, 3));
        8: apb_abort_rdlo(8'(ix * 8));
        default: apb(1'b0, 8'(ix * 8 + 4), 32'd0);
      endcase
    end
    idle(2);
    for (int i = 0; i < NREG; i++) chk("rf_contents", rfm[4'(i)], mm[4'(i)]);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
